// File: rtl/target_sequencer_if.sv
// Sequencer bundle: sweep control, hash-table port, cracker-core port, result record.
// Latency: none (wires only).
// Backpressure: the result record is valid/ready; the cracker port uses start/done pulses.
interface target_sequencer_if;
    // sweep control
    logic         start;
    logic         abort;
    logic [3:0]   first_sel;
    logic [3:0]   last_sel;
    logic         busy;
    logic         sweep_done;
    logic [4:0]   found_count;

    // registered 16-entry hash table
    logic [3:0]   selector;
    logic [127:0] target_in;

    // MD5 cracker core
    logic         cracker_start;
    logic         cracker_abort;
    logic [127:0] cracker_target;
    logic         cracker_done;
    logic         cracker_found;
    logic [31:0]  cracker_word;

    // result record
    logic         res_valid;
    logic         res_ready;
    logic [3:0]   res_sel;
    logic         res_found;
    logic [31:0]  res_word;

    // sequencer side
    modport master (
        input  start, abort, first_sel, last_sel,
        input  target_in,
        input  cracker_done, cracker_found, cracker_word,
        input  res_ready,
        output busy, sweep_done, found_count,
        output selector,
        output cracker_start, cracker_abort, cracker_target,
        output res_valid, res_sel, res_found, res_word
    );

    // environment side: controller, hash table, cracker core, result consumer
    modport slave (
        output start, abort, first_sel, last_sel,
        output target_in,
        output cracker_done, cracker_found, cracker_word,
        output res_ready,
        input  busy, sweep_done, found_count,
        input  selector,
        input  cracker_start, cracker_abort, cracker_target,
        input  res_valid, res_sel, res_found, res_word
    );
endinterface

// File: rtl/target_sequencer.sv
// Walks a 16-entry hash table from first_sel to last_sel (with wrap), launching the cracker per entry.
// Latency: 3 cycles start->cracker_start; 5 cycles per-target overhead beyond cracker run and res_ready stall.
// Backpressure: holds the result record in REPORT until res_ready; abort cancels from any busy state.
module target_sequencer (
    input  logic               CLK,
    input  logic               reset,
    target_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4,
        S_NEXT   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t       state_q,     state_d;
    logic         load_ph_q,   load_ph_d;   // 0: table samples selector, 1: table output valid
    logic [3:0]   sel_q,       sel_d;
    logic [3:0]   stop_q,      stop_d;
    logic [127:0] tgt_q,       tgt_d;
    logic [3:0]   res_sel_q,   res_sel_d;
    logic         res_found_q, res_found_d;
    logic [31:0]  res_word_q,  res_word_d;
    logic [4:0]   fcnt_q,      fcnt_d;
    logic         cabort_q,    cabort_d;

    logic abort_hit;

    // abort only matters once a sweep is in flight; IDLE ignores it
    assign abort_hit = bus.abort && (state_q != S_IDLE);

    // state and datapath registers, synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= S_IDLE;
            load_ph_q   <= 1'b0;
            sel_q       <= 4'd0;
            stop_q      <= 4'd0;
            tgt_q       <= '0;
            res_sel_q   <= 4'd0;
            res_found_q <= 1'b0;
            res_word_q  <= 32'd0;
            fcnt_q      <= 5'd0;
            cabort_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ph_q   <= load_ph_d;
            sel_q       <= sel_d;
            stop_q      <= stop_d;
            tgt_q       <= tgt_d;
            res_sel_q   <= res_sel_d;
            res_found_q <= res_found_d;
            res_word_q  <= res_word_d;
            fcnt_q      <= fcnt_d;
            cabort_q    <= cabort_d;
        end
    end

    // next-state and datapath updates; abort overrides every other input
    always_comb begin
        state_d     = state_q;
        load_ph_d   = load_ph_q;
        sel_d       = sel_q;
        stop_d      = stop_q;
        tgt_d       = tgt_q;
        res_sel_d   = res_sel_q;
        res_found_d = res_found_q;
        res_word_d  = res_word_q;
        fcnt_d      = fcnt_q;
        cabort_d    = 1'b0;

        if (abort_hit) begin
            state_d   = S_IDLE;
            load_ph_d = 1'b0;
            // the core only has work to cancel once it has been launched;
            // registering the pulse keeps it clear of cracker_start
            cabort_d  = (state_q == S_LAUNCH) || (state_q == S_RUN);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        sel_d     = bus.first_sel;
                        stop_d    = bus.last_sel;
                        fcnt_d    = 5'd0;
                        load_ph_d = 1'b0;
                        state_d   = S_LOAD;
                    end
                end

                S_LOAD: begin
                    // first cycle: table registers selector; second: capture its output
                    if (!load_ph_q) begin
                        load_ph_d = 1'b1;
                    end else begin
                        tgt_d     = bus.target_in;
                        load_ph_d = 1'b0;
                        state_d   = S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    state_d = S_RUN;
                end

                S_RUN: begin
                    if (bus.cracker_done) begin
                        res_sel_d   = sel_q;
                        res_found_d = bus.cracker_found;
                        res_word_d  = bus.cracker_found ? bus.cracker_word : 32'd0;
                        if (bus.cracker_found && (fcnt_q != 5'd16)) begin
                            fcnt_d = fcnt_q + 5'd1;
                        end
                        state_d = S_REPORT;
                    end
                end

                S_REPORT: begin
                    if (bus.res_ready) begin
                        state_d = S_NEXT;
                    end
                end

                S_NEXT: begin
                    if (sel_q == stop_q) begin
                        state_d = S_FINISH;
                    end else begin
                        // 4-bit add wraps 15 -> 0 for free
                        sel_d     = sel_q + 4'd1;
                        load_ph_d = 1'b0;
                        state_d   = S_LOAD;
                    end
                end

                S_FINISH: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.selector       = sel_q;
    assign bus.cracker_target = tgt_q;
    assign bus.cracker_start  = (state_q == S_LAUNCH);
    assign bus.cracker_abort  = cabort_q;
    assign bus.res_valid      = (state_q == S_REPORT);
    assign bus.res_sel        = res_sel_q;
    assign bus.res_found      = res_found_q;
    assign bus.res_word       = res_word_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.sweep_done     = (state_q == S_FINISH);
    assign bus.found_count    = fcnt_q;

    // launch and cancel to the core are mutually exclusive
    a_start_abort_excl: assert property (@(posedge CLK) disable iff (reset)
        !(bus.cracker_start && bus.cracker_abort));

    // at most one find per table entry
    a_fcnt_bound: assert property (@(posedge CLK) disable iff (reset)
        fcnt_q <= 5'd16);

    // an unaccepted record stays put unless the sweep is aborted
    a_res_hold: assert property (@(posedge CLK) disable iff (reset)
        (bus.res_valid && !bus.res_ready && !bus.abort)
        |=> (bus.res_valid && $stable({res_sel_q, res_found_q, res_word_q})));

    // the target only moves when leaving LOAD
    a_tgt_only_in_load: assert property (@(posedge CLK) disable iff (reset)
        (state_q != S_LOAD) |=> $stable(tgt_q));

endmodule

// File: tb/tb_target_sequencer.sv
module tb_target_sequencer;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    target_sequencer_if bus();

    target_sequencer dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // environment configuration
    logic [127:0] tbl      [16];
    logic [31:0]  word_tbl [16];
    logic [15:0]  found_mask;
    int           fixed_lat;
    bit           rand_lat;
    bit           noise_en;
    int           ready_mode;   // 0 tied high, 1 random, 2 hold low 7 cycles per record

    // observations of the DUT, for hand-computed literal checks
    logic [36:0]  rec_log[$];
    int           rvlen_log[$];
    logic [3:0]   launch_log[$];
    logic [127:0] tgt_log[$];
    int           launch_cyc_log[$];
    int           sd_cnt;
    int           ca_cnt;
    int           dut_rvlen;

    // behavioural model: sweep progress as events with their expected cycles
    bit          m_busy, m_rv, in_run;
    int          m_idx, m_stop, m_fc;
    int          e_start_at, e_finish_at, e_abort_at, zero_at;
    logic [36:0] e_rec;
    logic [127:0] prev_ct;

    task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [178:0] out_vec();
        return {bus.selector, bus.cracker_target, bus.cracker_start, bus.cracker_abort,
                bus.res_valid, bus.res_sel, bus.res_found, bus.res_word,
                bus.busy, bus.sweep_done, bus.found_count};
    endfunction

    function automatic logic [36:0] rec_at(input int i);
        if (i < rec_log.size()) return rec_log[i];
        return '1;
    endfunction

    function automatic logic [3:0] launch_at(input int i);
        if (i < launch_log.size()) return launch_log[i];
        return 4'hx;
    endfunction

    // registered 16-entry hash table
    always_ff @(posedge CLK) bus.target_in <= tbl[bus.selector];

    // cracker core: answers each launch after a latency, plus optional stray done pulses
    initial begin
        int cnt;
        logic [3:0] li;
        cnt = -1;
        li  = 4'd0;
        bus.cracker_done  = 1'b0;
        bus.cracker_found = 1'b0;
        bus.cracker_word  = 32'd0;
        forever begin
            @(posedge CLK); #1;
            bus.cracker_done  = 1'b0;
            bus.cracker_found = 1'b0;
            bus.cracker_word  = $urandom;
            if (reset || bus.cracker_abort) begin
                cnt = -1;
            end else if (bus.cracker_start) begin
                cnt = rand_lat ? int'($urandom_range(1, 12)) : fixed_lat;
                li  = bus.selector;
            end else if (cnt > 0) begin
                cnt--;
            end
            if (cnt == 0) begin
                bus.cracker_done  = 1'b1;
                bus.cracker_found = found_mask[li];
                bus.cracker_word  = word_tbl[li];
                cnt = -1;
            end else if (noise_en && $urandom_range(0, 29) == 0) begin
                bus.cracker_done  = 1'b1;
                bus.cracker_found = 1'($urandom_range(0, 1));
            end
        end
    end

    // result consumer
    initial begin
        int rc;
        rc = 0;
        bus.res_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            case (ready_mode)
                0: bus.res_ready = 1'b1;
                1: bus.res_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (!bus.res_valid) begin
                        rc = 0;
                        bus.res_ready = 1'b0;
                    end else begin
                        bus.res_ready = (rc >= 7);
                        rc++;
                    end
                end
            endcase
        end
    end

    // compare process: check outputs of this cycle, then advance the model with this cycle's inputs
    initial begin
        m_busy = 0; m_rv = 0; in_run = 0;
        m_idx = 0; m_stop = 0; m_fc = 0;
        e_start_at = -1; e_finish_at = -1; e_abort_at = -1; zero_at = -1;
        e_rec = '0; prev_ct = '0;
        sd_cnt = 0; ca_cnt = 0; dut_rvlen = 0;
        forever begin
            @(negedge CLK);
            cyc++;

            if (cyc == zero_at) chk("reset_outputs", 192'(out_vec()), 192'(0));
            chk("busy",          192'(bus.busy),          192'(m_busy));
            chk("cracker_start", 192'(bus.cracker_start), 192'(cyc == e_start_at));
            chk("cracker_abort", 192'(bus.cracker_abort), 192'(cyc == e_abort_at));
            chk("sweep_done",    192'(bus.sweep_done),    192'(cyc == e_finish_at));
            chk("res_valid",     192'(bus.res_valid),     192'(m_rv));
            chk("found_count",   192'(bus.found_count),   192'(m_fc));
            if (m_rv)
                chk("res_record", 192'({bus.res_sel, bus.res_found, bus.res_word}), 192'(e_rec));
            if (cyc == e_start_at) begin
                chk("launch_sel",    192'(bus.selector),       192'(m_idx));
                chk("launch_target", 192'(bus.cracker_target), 192'(tbl[m_idx[3:0]]));
            end
            if (cyc > 2 && cyc != zero_at && bus.cracker_target !== prev_ct)
                chk("target_moved_outside_load", 192'(cyc == e_start_at), 192'(1));
            prev_ct = bus.cracker_target;

            // DUT-side logs
            if (bus.cracker_start) begin
                launch_log.push_back(bus.selector);
                tgt_log.push_back(bus.cracker_target);
                launch_cyc_log.push_back(cyc);
            end
            if (bus.sweep_done)    sd_cnt++;
            if (bus.cracker_abort) ca_cnt++;
            if (bus.res_valid) dut_rvlen++;
            if (bus.res_valid && bus.res_ready) begin
                rec_log.push_back({bus.res_sel, bus.res_found, bus.res_word});
                rvlen_log.push_back(dut_rvlen);
            end
            if (!bus.res_valid || bus.res_ready) dut_rvlen = 0;

            // model update from the inputs sampled at the coming edge
            if (reset) begin
                m_busy = 0; m_rv = 0; in_run = 0; m_fc = 0; m_idx = 0;
                e_start_at = -1; e_finish_at = -1; e_abort_at = -1;
                zero_at = cyc + 1;
            end else if (!m_busy) begin
                if (bus.start) begin
                    m_busy = 1; m_idx = int'(bus.first_sel); m_stop = int'(bus.last_sel);
                    m_fc = 0; e_start_at = cyc + 3;
                end
            end else if (bus.abort) begin
                if (cyc == e_start_at || in_run) e_abort_at = cyc + 1;
                m_busy = 0; m_rv = 0; in_run = 0;
                if (e_start_at > cyc)  e_start_at  = -1;
                if (e_finish_at > cyc) e_finish_at = -1;
            end else if (cyc == e_finish_at) begin
                m_busy = 0;
            end else if (cyc == e_start_at) begin
                in_run = 1;
            end else if (in_run && bus.cracker_done) begin
                in_run = 0; m_rv = 1;
                e_rec = {4'(m_idx), bus.cracker_found, bus.cracker_found ? bus.cracker_word : 32'd0};
                if (bus.cracker_found) m_fc++;
            end else if (m_rv && bus.res_ready) begin
                m_rv = 0;
                if (m_idx == m_stop) begin
                    e_finish_at = cyc + 2;
                end else begin
                    m_idx = (m_idx + 1) % 16;
                    e_start_at = cyc + 4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #2;
    endtask

    task automatic clear_logs();
        rec_log.delete(); rvlen_log.delete(); launch_log.delete();
        tgt_log.delete(); launch_cyc_log.delete();
        sd_cnt = 0; ca_cnt = 0;
    endtask

    task automatic start_sweep(input logic [3:0] f, input logic [3:0] l);
        bus.first_sel = f;
        bus.last_sel  = l;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int i = 0;
        while (bus.busy && i < budget) begin tick(); i++; end
        chk(nm, 192'(bus.busy), 192'(0));
    endtask

    task automatic wait_launch(input string nm, input int budget);
        int i = 0;
        while (!bus.cracker_start && i < budget) begin tick(); i++; end
        chk(nm, 192'(bus.cracker_start), 192'(1));
    endtask

    task automatic wait_handshake(input string nm, input int budget);
        int i = 0;
        while (!(bus.res_valid && bus.res_ready) && i < budget) begin tick(); i++; end
        chk(nm, 192'(bus.res_valid && bus.res_ready), 192'(1));
    endtask

    // watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.first_sel = 4'd0; bus.last_sel = 4'd0;
        ready_mode = 0; fixed_lat = 10; rand_lat = 0; noise_en = 0;
        found_mask = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            tbl[i]      = {$urandom, $urandom, $urandom, $urandom};
            word_tbl[i] = $urandom | 32'h0000_0100;
        end
        tbl[0]      = 128'hf1d3ff8443297732862df21dc4e57262;
        word_tbl[1] = 32'h0000_0001;

        repeat (3) tick();
        chk("reset_state", 192'(out_vec()), 192'(0));
        reset = 1'b0;
        tick();

        // sweep 0..2, done 10 cycles after launch, found only on index 1
        clear_logs();
        found_mask = 16'h0002; fixed_lat = 10; ready_mode = 0;
        start_sweep(4'd0, 4'd2);
        wait_idle("t1_timeout", 500);
        chk("t1_nrec",        192'(rec_log.size()), 192'(3));
        chk("t1_rec0",        192'(rec_at(0)), 192'({4'd0, 1'b0, 32'h0}));
        chk("t1_rec1",        192'(rec_at(1)), 192'({4'd1, 1'b1, 32'h1}));
        chk("t1_rec2",        192'(rec_at(2)), 192'({4'd2, 1'b0, 32'h0}));
        chk("t1_target0",     192'(tgt_log.size() > 0 ? tgt_log[0] : 128'h0),
                              192'(128'hf1d3ff8443297732862df21dc4e57262));
        chk("t1_sweep_done",  192'(sd_cnt), 192'(1));
        chk("t1_found_count", 192'(bus.found_count), 192'(1));
        chk("t1_launch_gap",  192'(launch_cyc_log.size() > 1 ? launch_cyc_log[1] - launch_cyc_log[0] : 0),
                              192'(15));

        // wrapping sweep 14..1
        clear_logs();
        found_mask = 16'h0000; fixed_lat = 3;
        start_sweep(4'd14, 4'd1);
        wait_idle("t2_timeout", 500);
        chk("t2_nlaunch",    192'(launch_log.size()), 192'(4));
        chk("t2_order",      192'({launch_at(0), launch_at(1), launch_at(2), launch_at(3)}), 192'(16'hEF01));
        chk("t2_nrec",       192'(rec_log.size()), 192'(4));
        chk("t2_last_sel",   192'(rec_at(3) >> 33), 192'(1));
        chk("t2_sweep_done", 192'(sd_cnt), 192'(1));

        // stalled consumer and a start pulse during RUN
        clear_logs();
        found_mask = 16'h0008; fixed_lat = 5; ready_mode = 2;
        start_sweep(4'd3, 4'd4);
        wait_launch("t3_launch", 50);
        tick(); tick();
        start_sweep(4'd9, 4'd9);
        wait_idle("t3_timeout", 800);
        chk("t3_nrec",   192'(rec_log.size()), 192'(2));
        chk("t3_rec0",   192'(rec_at(0)), 192'({4'd3, 1'b1, word_tbl[3]}));
        chk("t3_rec1",   192'(rec_at(1)), 192'({4'd4, 1'b0, 32'h0}));
        chk("t3_stall",  192'(rvlen_log.size() > 0 ? rvlen_log[0] : 0), 192'(8));
        chk("t3_order",  192'({launch_at(0), launch_at(1)}), 192'(8'h34));
        chk("t3_found",  192'(bus.found_count), 192'(1));

        // abort during RUN
        clear_logs();
        ready_mode = 0; fixed_lat = 20;
        start_sweep(4'd6, 4'd8);
        wait_launch("t4_launch", 50);
        tick(); tick(); tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_busy",        192'(bus.busy), 192'(0));
        chk("t4_abort_pulse", 192'(bus.cracker_abort), 192'(1));
        chk("t4_res_valid",   192'(bus.res_valid), 192'(0));
        tick(); tick();
        chk("t4_abort_count", 192'(ca_cnt), 192'(1));
        chk("t4_no_done",     192'(sd_cnt), 192'(0));

        // reset in LOAD of the second target, then a single-entry sweep
        clear_logs();
        fixed_lat = 4; found_mask = 16'h0020;
        start_sweep(4'd2, 4'd5);
        wait_handshake("t5_hs", 100);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_reset_zero", 192'(out_vec()), 192'(0));
        clear_logs();
        start_sweep(4'd5, 4'd5);
        wait_idle("t5_timeout", 200);
        chk("t5_nrec",  192'(rec_log.size()), 192'(1));
        chk("t5_rec0",  192'(rec_at(0)), 192'({4'd5, 1'b1, word_tbl[5]}));
        chk("t5_order", 192'(launch_at(0)), 192'(5));
        chk("t5_nlaunch", 192'(launch_log.size()), 192'(1));

        // randomized sweeps; the first is a full 16-entry sweep with every target found
        ready_mode = 1; rand_lat = 1;
        for (int s = 0; s < 15; s++) begin
            int n;
            clear_logs();
            if (s == 0) begin
                found_mask = 16'hFFFF; noise_en = 0;
                start_sweep(4'd7, 4'd6);
            end else begin
                found_mask = 16'($urandom); noise_en = 1;
                start_sweep(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            n = 0;
            while (bus.busy && n < 3000) begin
                bus.abort = (s != 0) && ($urandom_range(0, 299) == 0);
                bus.start = ($urandom_range(0, 59) == 0);
                bus.first_sel = 4'($urandom_range(0, 15));
                bus.last_sel  = 4'($urandom_range(0, 15));
                tick();
                n++;
            end
            bus.abort = 1'b0;
            bus.start = 1'b0;
            chk("rand_timeout", 192'(bus.busy), 192'(0));
            if (s == 0) begin
                chk("full_sweep_count", 192'(bus.found_count), 192'(16));
                chk("full_sweep_nrec",  192'(rec_log.size()), 192'(16));
            end
            tick();
        end

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/target_sequencer.md
TARGET_SEQUENCER -- requirements
Module: target_sequencer

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning), clock and reset first:
 CLK  in  1  clock, all logic on rising edge
 reset  in  1  synchronous, active-high reset
 start  in  1  one-cycle pulse that begins a sweep
 abort  in  1  one-cycle pulse that cancels a sweep
 first_sel  in  4  first hash-table index, sampled on accepted start
 last_sel  in  4  last hash-table index (inclusive), sampled on accepted start
 selector  out  4  index driven to the registered 16-entry hash table
 target_in  in  128  hash-table output; valid 1 cycle after selector is sampled
 cracker_start  out  1  one-cycle launch pulse to the MD5 cracker core
 cracker_abort  out  1  one-cycle cancel pulse to the cracker core
 cracker_target  out  128  registered target hash held stable during RUN
 cracker_done  in  1  cracker finished the current target
 cracker_found  in  1  qualifies cracker_done: preimage found
 cracker_word  in  32  found 4-byte preimage, valid with cracker_done
 res_valid  out  1  result record available
 res_ready  in  1  consumer accepts the record
 res_sel  out  4  index of the reported target
 res_found  out  1  found flag of the reported target
 res_word  out  32  preimage, zero when res_found=0
 busy  out  1  high in every state except IDLE
 sweep_done  out  1  one-cycle pulse at sweep completion
 found_count  out  5  number of found targets in the current/last sweep
REQ-002 SHALL have no parameters; table depth is fixed at 16.

Function
REQ-003 SHALL implement states IDLE, LOAD, LAUNCH, RUN, REPORT, NEXT, FINISH.
REQ-004 IDLE: start=1 -> selector<=first_sel, stop index<=last_sel, found_count<=0, go to LOAD; all other inputs ignored.
REQ-005 LOAD SHALL last exactly 2 cycles (table registers selector, then output settles); on the last LOAD cycle cracker_target<=target_in; go to LAUNCH.
REQ-006 LAUNCH SHALL last 1 cycle with cracker_start=1; go to RUN.
REQ-007 RUN: cracker_done=1 -> capture res_sel=selector, res_found=cracker_found, res_word=cracker_found?cracker_word:0, found_count+=cracker_found, go to REPORT; cracker_done asserted in LOAD or LAUNCH SHALL be ignored.
REQ-008 REPORT: res_valid=1 and res_* stable until res_ready=1; the handshake completes in the cycle where res_valid and res_ready are both 1; go to NEXT; res_ready outside REPORT ignored.
REQ-009 NEXT (1 cycle): selector==stop index -> FINISH; else selector<=selector+1 modulo 16 (15 wraps to 0), go to LOAD.
REQ-010 first_sel>last_sel SHALL sweep with wrap (e.g. 14,15,0,1); first_sel==last_sel SHALL process exactly one target; maximum sweep is 16 targets.
REQ-011 FINISH (1 cycle): sweep_done=1; go to IDLE; found_count holds until next accepted start.
REQ-012 start while busy=1 SHALL be ignored.
REQ-013 abort in any non-IDLE state SHALL go to IDLE next cycle, drop res_valid, assert cracker_abort for 1 cycle only if abort arrived in LAUNCH or RUN, no sweep_done; abort has priority over start, cracker_done and res_ready in the same cycle.
REQ-014 cracker_target SHALL change only in LOAD; cracker_start and cracker_abort SHALL never both be 1.
REQ-015 found_count SHALL not exceed 16.
REQ-016 Per-target overhead excluding cracker run time and res_ready stall SHALL be 5 cycles (LOAD 2, LAUNCH 1, REPORT min 1, NEXT 1).

Reset
REQ-017 reset SHALL take priority over all inputs, including mid-sweep, and return to IDLE next edge.
REQ-018 After reset all outputs SHALL be 0: selector, cracker_target, cracker_start, cracker_abort, res_valid, res_sel, res_found, res_word, busy, sweep_done, found_count.

Verification
REQ-019 first_sel=0,last_sel=2, cracker done 10 cycles after each launch, found only on index 1 with word 0x00000001, res_ready tied 1 -> three records (0,0,0),(1,1,0x00000001),(2,0,0); cracker_target of index 0 = f1d3ff8443297732862df21dc4e57262; sweep_done once; found_count=1.
REQ-020 first_sel=14,last_sel=1 -> selector sequence 14,15,0,1; four records; FINISH after index 1.
REQ-021 res_ready held 0 for 7 cycles in REPORT -> res_* stable, no LOAD until handshake; second start pulse during RUN ignored.
REQ-022 abort during RUN -> cracker_abort pulse, busy=0 next cycle, no sweep_done, res_valid=0.
REQ-023 reset asserted in LOAD of second target -> all outputs 0 next cycle; subsequent start with first_sel=last_sel=5 processes only index 5.
